// File: rtl/pmem_lsu.sv
// Purpose : clocked, single-outstanding load/store front end to the simulation memory model.
// Latency : legal access accepted at edge N responds at edge N+LATENCY; faulted access at edge N+1.
// Backpr. : req_ready only in IDLE; a response is held stable until resp_ready, after which req_ready returns one cycle later.
//
// Ports:
//   clock, reset (async, active-low)
//   req_*  : request channel (valid/ready), write/addr/size/signed/wdata
//   resp_* : response channel (valid/ready), extended load data and fault flag
//   cnt_*  : wrapping counters of completed loads, stores and faulted requests
//   pmem_* : memory-model call port; pmem_call is high for exactly the one cycle in which
//            pmem_read/pmem_write is performed, and the model commits/returns on that cycle's
//            rising edge. pmem_rdata is the model's combinational read result for pmem_addr.
module pmem_lsu #(
    parameter int ADDR_W       = 32,
    parameter int LATENCY      = 1,
    parameter bit MISALIGN_ERR = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [31:0]       cnt_load,
    output logic [31:0]       cnt_store,
    output logic [31:0]       cnt_err,
    output logic              pmem_call,
    output logic              pmem_we,
    output logic [31:0]       pmem_addr,
    output logic [2:0]        pmem_len,
    output logic [31:0]       pmem_wdata,
    input  logic [31:0]       pmem_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

    localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

    state_t            r_state;
    logic [7:0]        r_lat;
    logic              r_fault;
    logic              r_write;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_size;
    logic              r_signed;
    logic [31:0]       r_wdata;
    logic              r_req_ready;
    logic              r_resp_valid;
    logic [31:0]       r_resp_rdata;
    logic              r_resp_err;
    logic [31:0]       r_cnt_load;
    logic [31:0]       r_cnt_store;
    logic [31:0]       r_cnt_err;

    logic              w_misal;
    logic              w_fault;
    logic [31:0]       w_load;
    logic [31:0]       w_addr32;

    // Fault decode on the live request so the decision is latched with the request.
    always_comb begin
        w_misal = 1'b0;
        case (req_size)
            2'd1:    w_misal = req_addr[0];
            2'd2:    w_misal = |req_addr[1:0];
            default: w_misal = 1'b0;
        endcase
        w_fault = (req_size == 2'd3) || (MISALIGN_ERR && w_misal);
    end

    // Load extension; word loads pass through whatever req_signed says.
    always_comb begin
        w_load = pmem_rdata;
        case (r_size)
            2'd0:    w_load = {{24{r_signed & pmem_rdata[7]}},  pmem_rdata[7:0]};
            2'd1:    w_load = {{16{r_signed & pmem_rdata[15]}}, pmem_rdata[15:0]};
            default: w_load = pmem_rdata;
        endcase
    end

    always_comb begin
        pmem_len = 3'd4;
        case (r_size)
            2'd0:    pmem_len = 3'd1;
            2'd1:    pmem_len = 3'd2;
            default: pmem_len = 3'd4;
        endcase
    end

    // The memory model always sees a 32-bit address.
    if (ADDR_W >= 32) begin : g_addr_trunc
        assign w_addr32 = r_addr[31:0];
    end else begin : g_addr_zext
        assign w_addr32 = {{(32-ADDR_W){1'b0}}, r_addr};
    end

    // Faulted requests also pass through BUSY (with a zero count) so they respond
    // one edge after acceptance, but they never raise pmem_call.
    assign pmem_call  = (r_state == S_BUSY) && (r_lat == 8'd0) && !r_fault;
    assign pmem_we    = r_write;
    assign pmem_addr  = w_addr32;
    assign pmem_wdata = r_wdata;

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;
    assign cnt_load   = r_cnt_load;
    assign cnt_store  = r_cnt_store;
    assign cnt_err    = r_cnt_err;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_lat        <= 8'd0;
            r_fault      <= 1'b0;
            r_write      <= 1'b0;
            r_addr       <= '0;
            r_size       <= 2'd0;
            r_signed     <= 1'b0;
            r_wdata      <= 32'd0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'd0;
            r_resp_err   <= 1'b0;
            r_cnt_load   <= 32'd0;
            r_cnt_store  <= 32'd0;
            r_cnt_err    <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_write     <= req_write;
                        r_addr      <= req_addr;
                        r_size      <= req_size;
                        r_signed    <= req_signed;
                        r_wdata     <= req_wdata;
                        r_fault     <= w_fault;
                        r_lat       <= w_fault ? 8'd0 : LAT_M1;
                        r_req_ready <= 1'b0;
                        r_state     <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (r_lat != 8'd0) begin
                        r_lat <= r_lat - 8'd1;
                    end else begin
                        r_resp_valid <= 1'b1;
                        r_state      <= S_RESP;
                        if (r_fault) begin
                            r_resp_err   <= 1'b1;
                            r_resp_rdata <= 32'd0;
                            r_cnt_err    <= r_cnt_err + 32'd1;
                        end else begin
                            r_resp_err <= 1'b0;
                            if (r_write) begin
                                r_resp_rdata <= 32'd0;
                                r_cnt_store  <= r_cnt_store + 32'd1;
                            end else begin
                                r_resp_rdata <= w_load;
                                r_cnt_load   <= r_cnt_load + 32'd1;
                            end
                        end
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                        r_state      <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pmem_lsu.sv
// Purpose : directed bench for pmem_lsu with a byte-array memory model behind the pmem_* call port.
// Latency : two instances, LATENCY=1 (table vectors, force-wrap) and LATENCY=3 (stall, reset).
// Backpr. : resp_ready is driven low except for the single handshake cycle of each transaction.
module tb_pmem_lsu;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        rst_n;
    logic        v1, v3;
    logic        req_write, req_signed, resp_ready;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;

    logic        rdy1, rvld1, err1, call1, we1;
    logic [31:0] rdata1, cl1, cs1, ce1, addr1, wd1, rd1;
    logic [2:0]  len1;
    logic        rdy3, rvld3, err3, call3, we3;
    logic [31:0] rdata3, cl3, cs3, ce3, addr3, wd3, rd3;
    logic [2:0]  len3;

    pmem_lsu #(.ADDR_W(32), .LATENCY(1), .MISALIGN_ERR(1'b1)) u_l1 (
        .clock(clock), .reset(rst_n),
        .req_valid(v1), .req_ready(rdy1), .req_write(req_write), .req_addr(req_addr),
        .req_size(req_size), .req_signed(req_signed), .req_wdata(req_wdata),
        .resp_valid(rvld1), .resp_ready(resp_ready), .resp_rdata(rdata1), .resp_err(err1),
        .cnt_load(cl1), .cnt_store(cs1), .cnt_err(ce1),
        .pmem_call(call1), .pmem_we(we1), .pmem_addr(addr1), .pmem_len(len1),
        .pmem_wdata(wd1), .pmem_rdata(rd1)
    );

    pmem_lsu #(.ADDR_W(32), .LATENCY(3), .MISALIGN_ERR(1'b1)) u_l3 (
        .clock(clock), .reset(rst_n),
        .req_valid(v3), .req_ready(rdy3), .req_write(req_write), .req_addr(req_addr),
        .req_size(req_size), .req_signed(req_signed), .req_wdata(req_wdata),
        .resp_valid(rvld3), .resp_ready(resp_ready), .resp_rdata(rdata3), .resp_err(err3),
        .cnt_load(cl3), .cnt_store(cs3), .cnt_err(ce3),
        .pmem_call(call3), .pmem_we(we3), .pmem_addr(addr3), .pmem_len(len3),
        .pmem_wdata(wd3), .pmem_rdata(rd3)
    );

    // Shared memory model: 256 bytes addressed by addr[7:0]; byte 0x04 preloaded with 0xF0.
    logic [7:0] mem [256] = '{4: 8'hF0, default: 8'h00};
    int nrd1 = 0, nwr1 = 0, nrd3 = 0, nwr3 = 0;

    always_comb begin
        rd1 = {mem[8'(addr1[7:0] + 8'd3)], mem[8'(addr1[7:0] + 8'd2)],
               mem[8'(addr1[7:0] + 8'd1)], mem[addr1[7:0]]};
        rd3 = {mem[8'(addr3[7:0] + 8'd3)], mem[8'(addr3[7:0] + 8'd2)],
               mem[8'(addr3[7:0] + 8'd1)], mem[addr3[7:0]]};
    end

    always @(posedge clock) begin
        if (call1) begin
            if (we1) begin
                for (int b = 0; b < int'(len1); b++) mem[8'(addr1[7:0] + 8'(b))] <= wd1[8*b +: 8];
                nwr1++;
            end else begin
                nrd1++;
            end
        end
        if (call3) begin
            if (we3) begin
                for (int b = 0; b < int'(len3); b++) mem[8'(addr3[7:0] + 8'(b))] <= wd3[8*b +: 8];
                nwr3++;
            end else begin
                nrd3++;
            end
        end
    end

    // sel picks which instance the transaction task drives and observes.
    logic        sel;
    logic        m_rdy, m_rvld, m_err;
    logic [31:0] m_rdata;
    assign m_rdy   = sel ? rdy3   : rdy1;
    assign m_rvld  = sel ? rvld3  : rvld1;
    assign m_err   = sel ? err3   : err1;
    assign m_rdata = sel ? rdata3 : rdata1;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
        end
    endtask

    // One request on the selected instance; returns response data/err and the number of
    // edges from acceptance to resp_valid. Holds resp_ready low for 'hold' cycles first.
    task automatic xact(input logic s, input logic w, input logic [31:0] a, input logic [1:0] sz,
                        input logic sg, input logic [31:0] wd, input int hold,
                        output logic [31:0] rd, output logic er, output int lat);
        @(negedge clock);
        sel = s; req_write = w; req_addr = a; req_size = sz; req_signed = sg; req_wdata = wd;
        chk("req_ready_idle", {31'd0, m_rdy}, 32'd1);
        if (s) v3 = 1'b1; else v1 = 1'b1;
        @(posedge clock);
        @(negedge clock);
        v1 = 1'b0; v3 = 1'b0;
        lat = 0;
        while (!m_rvld && lat < 40) begin
            @(posedge clock);
            lat++;
            @(negedge clock);
        end
        rd = m_rdata;
        er = m_err;
        for (int i = 0; i < hold; i++) begin
            @(posedge clock);
            @(negedge clock);
            chk("stall_resp_valid", {31'd0, m_rvld}, 32'd1);
            chk("stall_rdata", m_rdata, rd);
            chk("stall_err", {31'd0, m_err}, {31'd0, er});
            chk("stall_req_ready", {31'd0, m_rdy}, 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        resp_ready = 1'b0;
        chk("req_ready_after_hs", {31'd0, m_rdy}, 32'd1);
        chk("resp_valid_after_hs", {31'd0, m_rvld}, 32'd0);
    endtask

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t        vecs [13];
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          calls0;

    initial begin
        vecs[0]  = '{1'b0, 32'h8000_0004, 2'd0, 1'b1, 32'h0,         32'hFFFF_FFF0, 1'b0};
        vecs[1]  = '{1'b0, 32'h8000_0004, 2'd0, 1'b0, 32'h0,         32'h0000_00F0, 1'b0};
        vecs[2]  = '{1'b1, 32'h8000_0010, 2'd2, 1'b0, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
        vecs[3]  = '{1'b0, 32'h8000_0012, 2'd1, 1'b0, 32'h0,         32'h0000_DEAD, 1'b0};
        vecs[4]  = '{1'b0, 32'h8000_0012, 2'd1, 1'b1, 32'h0,         32'hFFFF_DEAD, 1'b0};
        vecs[5]  = '{1'b0, 32'h8000_0010, 2'd2, 1'b1, 32'h0,         32'hDEAD_BEEF, 1'b0};
        vecs[6]  = '{1'b0, 32'h8000_0013, 2'd0, 1'b1, 32'h0,         32'hFFFF_FFDE, 1'b0};
        vecs[7]  = '{1'b0, 32'h8000_0001, 2'd1, 1'b0, 32'h0,         32'h0000_0000, 1'b1};
        vecs[8]  = '{1'b0, 32'h8000_0010, 2'd3, 1'b0, 32'h0,         32'h0000_0000, 1'b1};
        vecs[9]  = '{1'b1, 32'h8000_0020, 2'd0, 1'b0, 32'hAABB_CC11, 32'h0000_0000, 1'b0};
        vecs[10] = '{1'b0, 32'h8000_0020, 2'd2, 1'b0, 32'h0,         32'h0000_0011, 1'b0};
        vecs[11] = '{1'b0, 32'h8000_0010, 2'd1, 1'b1, 32'h0,         32'hFFFF_BEEF, 1'b0};
        vecs[12] = '{1'b0, 32'h8000_0022, 2'd2, 1'b0, 32'h0,         32'h0000_0000, 1'b1};

        rst_n = 1'b0; v1 = 1'b0; v3 = 1'b0; sel = 1'b0; resp_ready = 1'b0;
        req_write = 1'b0; req_addr = 32'h0; req_size = 2'd0; req_signed = 1'b0; req_wdata = 32'h0;

        // Reset state while reset is held.
        #12;
        chk("rst_req_ready", {31'd0, rdy1}, 32'd1);
        chk("rst_resp_valid", {31'd0, rvld1}, 32'd0);
        chk("rst_resp_err", {31'd0, err1}, 32'd0);
        chk("rst_rdata", rdata1, 32'd0);
        chk("rst_cnt_load", cl1, 32'd0);
        chk("rst_cnt_store", cs1, 32'd0);
        chk("rst_cnt_err", ce1, 32'd0);
        chk("rst_req_ready3", {31'd0, rdy3}, 32'd1);
        @(negedge clock);
        rst_n = 1'b1;

        // Table vectors on the LATENCY=1 instance.
        for (int i = 0; i < 13; i++) begin
            calls0 = nrd1 + nwr1;
            xact(1'b0, vecs[i].w, vecs[i].a, vecs[i].sz, vecs[i].sg, vecs[i].wd, 0, rd, er, lat);
            chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
            chk($sformatf("v%0d_err", i), {31'd0, er}, {31'd0, vecs[i].exp_err});
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'd1);
            chk($sformatf("v%0d_calls", i), 32'(nrd1 + nwr1 - calls0), vecs[i].exp_err ? 32'd0 : 32'd1);
        end
        chk("l1_cnt_load", cl1, 32'd8);
        chk("l1_cnt_store", cs1, 32'd2);
        chk("l1_cnt_err", ce1, 32'd3);
        chk("l1_reads", 32'(nrd1), 32'd8);
        chk("l1_writes", 32'(nwr1), 32'd2);
        chk("byte_store_neighbour", {24'd0, mem[8'h21]}, 32'd0);

        // Error counter wrap.
        force u_l1.r_cnt_err = 32'hFFFF_FFFF;
        @(negedge clock);
        release u_l1.r_cnt_err;
        chk("cnt_err_seeded", ce1, 32'hFFFF_FFFF);
        xact(1'b0, 1'b0, 32'h8000_0003, 2'd2, 1'b0, 32'h0, 0, rd, er, lat);
        chk("wrap_err", {31'd0, er}, 32'd1);
        chk("cnt_err_wrapped", ce1, 32'd0);

        // LATENCY=3 load with resp_ready held low for 5 cycles.
        xact(1'b1, 1'b0, 32'h8000_0010, 2'd2, 1'b0, 32'h0, 5, rd, er, lat);
        chk("l3_rdata", rd, 32'hDEAD_BEEF);
        chk("l3_err", {31'd0, er}, 32'd0);
        chk("l3_latency", 32'(lat), 32'd3);
        chk("l3_cnt_load", cl3, 32'd1);

        // Reset two cycles after a LATENCY=3 store is accepted: the write must never happen.
        calls0 = nwr3;
        @(negedge clock);
        sel = 1'b1; req_write = 1'b1; req_addr = 32'h8000_0030; req_size = 2'd2; req_wdata = 32'h1234_5678;
        v3 = 1'b1;
        @(posedge clock);
        @(negedge clock);
        v3 = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clock);
        chk("mid_rst_writes", 32'(nwr3 - calls0), 32'd0);
        chk("mid_rst_mem", {mem[8'h33], mem[8'h32], mem[8'h31], mem[8'h30]}, 32'd0);
        chk("mid_rst_req_ready", {31'd0, rdy3}, 32'd1);
        chk("mid_rst_resp_valid", {31'd0, rvld3}, 32'd0);
        chk("mid_rst_rdata", rdata3, 32'd0);
        chk("mid_rst_cnt_load", cl3, 32'd0);
        chk("mid_rst_cnt_store", cs3, 32'd0);
        chk("mid_rst_cnt_load_l1", cl1, 32'd0);
        rst_n = 1'b1;

        // The next request completes normally.
        xact(1'b1, 1'b1, 32'h8000_0030, 2'd2, 1'b0, 32'h1234_5678, 0, rd, er, lat);
        chk("post_rst_latency", 32'(lat), 32'd3);
        chk("post_rst_err", {31'd0, er}, 32'd0);
        chk("post_rst_mem", {mem[8'h33], mem[8'h32], mem[8'h31], mem[8'h30]}, 32'h1234_5678);
        chk("post_rst_cnt_store", cs3, 32'd1);
        chk("post_rst_writes", 32'(nwr3 - calls0), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
